// File: rtl/uart_bridge_frame_rx.sv
// UART bridge target: 8N1 byte receiver plus request-frame decoder.
// Each complete write/read frame is presented on a valid/ready request port.
module uart_bridge_frame_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 8,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_rx,
   output logic              req_valid,
   input  logic              req_ready,
   output logic              req_write,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   output logic              frame_err,
   output logic              overrun
);
   localparam int TMR_W      = $clog2(CLKS_PER_BIT);
   localparam int TO_LIMIT   = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TO_W       = $clog2(TO_LIMIT + 1);
   localparam int ADDR_BYTES = ADDR_W / 8;
   localparam int DATA_BYTES = DATA_W / 8;
   localparam logic [TMR_W-1:0] HALF_M1 = TMR_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TMR_W-1:0] FULL_M1 = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [6:0]       SYNC_PAT = 7'b1010_010;

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;
   typedef enum logic [1:0] {F_HDR, F_ADDR, F_DATA, F_EMIT} frame_state_t;

   logic rx_meta_reg, rx_sync_reg, rx_prev_reg;
   byte_state_t bstate_reg, bstate_next;
   logic [TMR_W-1:0] timer_reg, timer_next;
   logic [2:0] bit_cnt_reg, bit_cnt_next;
   logic [7:0] shift_reg, shift_next;
   logic byte_strobe, stop_err, start_edge;

   frame_state_t fstate_reg, fstate_next;
   logic [1:0] bcnt_reg, bcnt_next;
   logic write_flag_reg, write_flag_next;
   logic [ADDR_W-1:0] addr_acc_reg, addr_acc_next;
   logic [DATA_W-1:0] data_acc_reg, data_acc_next;
   logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
   logic req_valid_reg, req_valid_next, req_write_reg, req_write_next;
   logic [ADDR_W-1:0] req_addr_reg, req_addr_next;
   logic [DATA_W-1:0] req_wdata_reg, req_wdata_next;
   logic frame_err_reg, frame_err_next, overrun_reg, overrun_next;
   logic frame_take, err;

   assign start_edge = rx_prev_reg & ~rx_sync_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_reg    <= 1'b1;
         rx_sync_reg    <= 1'b1;
         rx_prev_reg    <= 1'b1;
         bstate_reg     <= B_IDLE;
         timer_reg      <= '0;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         fstate_reg     <= F_HDR;
         bcnt_reg       <= '0;
         write_flag_reg <= 1'b0;
         addr_acc_reg   <= '0;
         data_acc_reg   <= '0;
         to_cnt_reg     <= '0;
         req_valid_reg  <= 1'b0;
         req_write_reg  <= 1'b0;
         req_addr_reg   <= '0;
         req_wdata_reg  <= '0;
         frame_err_reg  <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         rx_meta_reg    <= uart_rx;
         rx_sync_reg    <= rx_meta_reg;
         rx_prev_reg    <= rx_sync_reg;
         bstate_reg     <= bstate_next;
         timer_reg      <= timer_next;
         bit_cnt_reg    <= bit_cnt_next;
         shift_reg      <= shift_next;
         fstate_reg     <= fstate_next;
         bcnt_reg       <= bcnt_next;
         write_flag_reg <= write_flag_next;
         addr_acc_reg   <= addr_acc_next;
         data_acc_reg   <= data_acc_next;
         to_cnt_reg     <= to_cnt_next;
         req_valid_reg  <= req_valid_next;
         req_write_reg  <= req_write_next;
         req_addr_reg   <= req_addr_next;
         req_wdata_reg  <= req_wdata_next;
         frame_err_reg  <= frame_err_next;
         overrun_reg    <= overrun_next;
      end
   end

   // Byte receiver: start bit checked at mid-bit, then every sample lands mid-bit.
   always_comb begin
      bstate_next  = bstate_reg;
      timer_next   = timer_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      byte_strobe  = 1'b0;
      stop_err     = 1'b0;
      case (bstate_reg)
         B_IDLE: begin
            if (start_edge) begin
               bstate_next = B_START;
               timer_next  = '0;
            end
         end
         B_START: begin
            if (timer_reg == HALF_M1) begin
               timer_next   = '0;
               bit_cnt_next = '0;
               bstate_next  = rx_sync_reg ? B_IDLE : B_DATA;
            end else begin
               timer_next = timer_reg + TMR_W'(1);
            end
         end
         B_DATA: begin
            if (timer_reg == FULL_M1) begin
               timer_next   = '0;
               shift_next   = {rx_sync_reg, shift_reg[7:1]};
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) bstate_next = B_STOP;
            end else begin
               timer_next = timer_reg + TMR_W'(1);
            end
         end
         default: begin
            if (timer_reg == FULL_M1) begin
               timer_next  = '0;
               bstate_next = B_IDLE;
               byte_strobe = rx_sync_reg;
               stop_err    = ~rx_sync_reg;
            end else begin
               timer_next = timer_reg + TMR_W'(1);
            end
         end
      endcase
   end

   // A byte arriving in the same cycle the pending request is accepted is still consumed.
   assign frame_take   = byte_strobe & (~req_valid_reg | req_ready);
   assign overrun_next = byte_strobe & req_valid_reg & ~req_ready;

   always_comb begin
      fstate_next     = fstate_reg;
      bcnt_next       = bcnt_reg;
      write_flag_next = write_flag_reg;
      addr_acc_next   = addr_acc_reg;
      data_acc_next   = data_acc_reg;
      to_cnt_next     = to_cnt_reg;
      req_valid_next  = req_valid_reg & ~req_ready;
      req_write_next  = req_write_reg;
      req_addr_next   = req_addr_reg;
      req_wdata_next  = req_wdata_reg;
      err             = 1'b0;
      case (fstate_reg)
         F_HDR: begin
            if (frame_take) begin
               if (shift_reg[7:1] == SYNC_PAT) begin
                  write_flag_next = shift_reg[0];
                  bcnt_next       = '0;
                  fstate_next     = F_ADDR;
               end else begin
                  err = 1'b1;
               end
            end
         end
         F_ADDR: begin
            if (frame_take) begin
               addr_acc_next = (addr_acc_reg << 8) | ADDR_W'(shift_reg);
               if (bcnt_reg == 2'(ADDR_BYTES - 1)) begin
                  bcnt_next   = '0;
                  fstate_next = write_flag_reg ? F_DATA : F_EMIT;
               end else begin
                  bcnt_next = bcnt_reg + 2'd1;
               end
            end
         end
         F_DATA: begin
            if (frame_take) begin
               data_acc_next = (data_acc_reg << 8) | DATA_W'(shift_reg);
               if (bcnt_reg == 2'(DATA_BYTES - 1)) begin
                  bcnt_next   = '0;
                  fstate_next = F_EMIT;
               end else begin
                  bcnt_next = bcnt_reg + 2'd1;
               end
            end
         end
         default: begin
            req_valid_next = 1'b1;
            req_write_next = write_flag_reg;
            req_addr_next  = addr_acc_reg;
            req_wdata_next = write_flag_reg ? data_acc_reg : '0;
            fstate_next    = F_HDR;
         end
      endcase

      // Inter-byte gap timer runs only while idle mid-frame with nothing pending.
      if (!(fstate_reg == F_ADDR || fstate_reg == F_DATA) || bstate_reg != B_IDLE || start_edge) begin
         to_cnt_next = '0;
      end else if (!req_valid_reg) begin
         if (to_cnt_reg == TO_W'(TO_LIMIT - 1)) begin
            to_cnt_next = '0;
            err         = 1'b1;
            fstate_next = F_HDR;
         end else begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
         end
      end

      if (stop_err) begin
         err         = 1'b1;
         fstate_next = F_HDR;
      end
   end

   assign frame_err_next = err & ~overrun_next;

   assign req_valid = req_valid_reg;
   assign req_write = req_write_reg;
   assign req_addr  = req_addr_reg;
   assign req_wdata = req_wdata_reg;
   assign frame_err = frame_err_reg;
   assign overrun   = overrun_reg;
endmodule

// File: tb/tb_uart_bridge_frame_rx.sv
// Directed bench for uart_bridge_frame_rx: serial frames in, request port checked.
// Inputs change 1 time unit after the rising edge; monitors sample on the falling edge.
module tb_uart_bridge_frame_rx;
   localparam int CPB = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uart_rx = 1'b1;
   logic        req_ready = 1'b0;
   logic        req_valid, req_write, frame_err, overrun;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;

   int errors = 0;
   int checks = 0;
   int err_cnt = 0, ovr_cnt = 0, acc_cnt = 0, both_cnt = 0, vld_rise = 0;
   logic        vld_d = 1'b0;
   logic        acc_write = 1'b0;
   logic [15:0] acc_addr = '0;
   logic [7:0]  acc_wdata = '0;

   uart_bridge_frame_rx #(
      .CLKS_PER_BIT(CPB), .ADDR_W(16), .DATA_W(8), .TIMEOUT_BITS(4)
   ) dut (
      .clk(clk), .rst(rst), .uart_rx(uart_rx),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) err_cnt <= err_cnt + 1;
         if (overrun) ovr_cnt <= ovr_cnt + 1;
         if (frame_err && overrun) both_cnt <= both_cnt + 1;
         if (req_valid && !vld_d) vld_rise <= vld_rise + 1;
         vld_d <= req_valid;
         if (req_valid && req_ready) begin
            acc_cnt   <= acc_cnt + 1;
            acc_write <= req_write;
            acc_addr  <= req_addr;
            acc_wdata <= req_wdata;
            $display("request accepted: write=%0d addr=%04h wdata=%02h", req_write, req_addr, req_wdata);
         end
      end else begin
         vld_d <= 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      ticks(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         ticks(CPB);
      end
      uart_rx = stop_bit;
      ticks(CPB);
      uart_rx = 1'b1;
      ticks(3);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (req_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check(tag, {31'd0, req_valid}, 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      // reset state
      ticks(3);
      check("rst_valid", {31'd0, req_valid}, 32'd0);
      check("rst_write", {31'd0, req_write}, 32'd0);
      check("rst_addr", {16'd0, req_addr}, 32'd0);
      check("rst_wdata", {24'd0, req_wdata}, 32'd0);
      check("rst_ferr", {31'd0, frame_err}, 32'd0);
      check("rst_ovr", {31'd0, overrun}, 32'd0);
      rst = 1'b0;
      ticks(5);

      // 1: write 0x1234 <- 0x5A with ready held high
      req_ready = 1'b1;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h5A, 1'b1);
      ticks(4);
      $display("test 1: write frame done");
      check("t1_acc_cnt", acc_cnt, 1);
      check("t1_vld_rise", vld_rise, 1);
      check("t1_write", {31'd0, acc_write}, 32'd1);
      check("t1_addr", {16'd0, acc_addr}, 32'h1234);
      check("t1_wdata", {24'd0, acc_wdata}, 32'h5A);
      check("t1_err", err_cnt, 0);
      check("t1_valid_low", {31'd0, req_valid}, 32'd0);

      // 2: read 0x0040 held pending for 10 cycles
      req_ready = 1'b0;
      send_byte(8'hA4, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h40, 1'b1);
      wait_valid("t2_valid_seen");
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (!(req_valid === 1'b1 && req_write === 1'b0 && req_addr === 16'h0040 && req_wdata === 8'h00))
            bad++;
         tick();
      end
      check("t2_stable_bad_cycles", bad, 0);
      req_ready = 1'b1;
      check("t2_valid_before_accept", {31'd0, req_valid}, 32'd1);
      tick();
      check("t2_valid_after_accept", {31'd0, req_valid}, 32'd0);
      $display("test 2: read frame held and accepted");
      check("t2_acc_cnt", acc_cnt, 2);
      check("t2_addr", {16'd0, acc_addr}, 32'h0040);
      check("t2_write", {31'd0, acc_write}, 32'd0);
      check("t2_wdata", {24'd0, acc_wdata}, 32'd0);

      // 3: bad stop bit on second byte, then a clean write
      send_byte(8'hA5, 1'b1);
      send_byte(8'h12, 1'b0);
      send_byte(8'hA5, 1'b1);
      send_byte(8'hAB, 1'b1);
      send_byte(8'hCD, 1'b1);
      send_byte(8'h01, 1'b1);
      ticks(4);
      $display("test 3: bad stop bit then write frame");
      check("t3_err", err_cnt, 1);
      check("t3_acc_cnt", acc_cnt, 3);
      check("t3_addr", {16'd0, acc_addr}, 32'hABCD);
      check("t3_wdata", {24'd0, acc_wdata}, 32'h01);
      check("t3_write", {31'd0, acc_write}, 32'd1);

      // 4: bad header then read 0x0010
      send_byte(8'h33, 1'b1);
      send_byte(8'hA4, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h10, 1'b1);
      ticks(4);
      $display("test 4: bad header then read frame");
      check("t4_err", err_cnt, 2);
      check("t4_acc_cnt", acc_cnt, 4);
      check("t4_addr", {16'd0, acc_addr}, 32'h0010);
      check("t4_write", {31'd0, acc_write}, 32'd0);

      // 5: inter-byte timeout, then read 0x0008
      send_byte(8'hA5, 1'b1);
      send_byte(8'h12, 1'b1);
      ticks(40);
      check("t5_timeout_err", err_cnt, 3);
      send_byte(8'hA4, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h08, 1'b1);
      ticks(4);
      $display("test 5: timeout then read frame");
      check("t5_acc_cnt", acc_cnt, 5);
      check("t5_addr", {16'd0, acc_addr}, 32'h0008);
      check("t5_write", {31'd0, acc_write}, 32'd0);

      // 6: overrun while a request is pending, then reset mid-byte
      req_ready = 1'b0;
      send_byte(8'hA4, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h40, 1'b1);
      wait_valid("t6_valid_seen");
      send_byte(8'hFF, 1'b1);
      ticks(2);
      $display("test 6: overrun byte sent with request pending");
      check("t6_ovr", ovr_cnt, 1);
      check("t6_err_unchanged", err_cnt, 3);
      check("t6_both", both_cnt, 0);
      check("t6_valid_held", {31'd0, req_valid}, 32'd1);
      check("t6_addr_held", {16'd0, req_addr}, 32'h0040);
      check("t6_write_held", {31'd0, req_write}, 32'd0);
      uart_rx = 1'b0;
      ticks(12);
      rst = 1'b1;
      tick();
      check("t6_rst_valid", {31'd0, req_valid}, 32'd0);
      check("t6_rst_addr", {16'd0, req_addr}, 32'd0);
      check("t6_rst_ferr", {31'd0, frame_err}, 32'd0);
      check("t6_rst_ovr", {31'd0, overrun}, 32'd0);
      uart_rx = 1'b1;
      ticks(3);
      rst = 1'b0;
      ticks(20);
      check("t6_post_rst_valid", {31'd0, req_valid}, 32'd0);
      req_ready = 1'b1;
      send_byte(8'hA4, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h22, 1'b1);
      ticks(4);
      $display("test 6: read frame after reset");
      check("t6_recover_cnt", acc_cnt, 6);
      check("t6_recover_addr", {16'd0, acc_addr}, 32'h0022);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
